// File: rtl/eu_operand_sequencer_pkg.sv
// Shared types and constants for the execution-unit operand sequencer.
// The FSM state, the instruction record and the default stall counter width live here.
package eu_operand_sequencer_pkg;

  localparam int EU_SEQ_DATA_W      = 32;
  localparam int EU_SEQ_ADDR_W      = 8;
  localparam int EU_SEQ_OPC_W       = 4;
  localparam int EU_SEQ_DEST_W      = 8;
  localparam int EU_SEQ_STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE
  } type_euseq_state;

  typedef struct packed {
    logic                     is_imm;
    logic [EU_SEQ_DATA_W-1:0] imm;
    logic [EU_SEQ_ADDR_W-1:0] addr;
  } type_euseq_operand;

  typedef struct packed {
    logic [EU_SEQ_OPC_W-1:0]  opcode;
    logic [EU_SEQ_DEST_W-1:0] dest;
    type_euseq_operand        op0;
    type_euseq_operand        op1;
  } type_euseq_instr;

endpackage

// File: rtl/eu_operand_slot.sv
// One operand lane: request/have/orphan tracking, request address and operand data register.
// The top level drives it with the FSM state and the accept/retire/flush events.
module eu_operand_slot #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              load_is_imm_i,
  input  logic [DATA_W-1:0] load_imm_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic              fetch_i,
  input  logic              retire_i,
  output logic              req_valid_o,
  output logic [ADDR_W-1:0] req_addr_o,
  input  logic              req_ready_i,
  input  logic              resp_valid_i,
  input  logic [DATA_W-1:0] resp_data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              have_next_o,
  output logic              orphan_o,
  output logic              proto_err_o
);

  logic              req_done_q, req_done_d;
  logic              have_q, have_d;
  logic              orphan_q, orphan_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic req_hs;
  logic pending;
  logic capture;

  assign req_valid_o = fetch_i && !req_done_q && !orphan_q;
  assign req_hs      = req_valid_o && req_ready_i;
  assign pending     = req_done_q && !have_q;
  assign capture     = resp_valid_i && pending && !orphan_q;
  assign have_next_o = have_q || capture;
  assign proto_err_o = resp_valid_i && !pending && !orphan_q;
  assign req_addr_o  = addr_q;
  assign data_o      = data_q;
  assign orphan_o    = orphan_q;

  always_comb begin
    // NOTE: every _d takes its current value first so no path leaves it unassigned (no latch).
    req_done_d = req_done_q;
    have_d     = have_q;
    orphan_d   = orphan_q;
    data_d     = data_q;
    addr_d     = addr_q;

    if (resp_valid_i && orphan_q) orphan_d = 1'b0;

    if (flush_i) begin
      // A request the buffer has accepted but not yet answered will still answer later.
      if ((req_done_q || req_hs) && !have_q && !resp_valid_i) orphan_d = 1'b1;
      req_done_d = 1'b0;
      have_d     = 1'b0;
    end else begin
      if (req_hs) req_done_d = 1'b1;
      if (capture) begin
        data_d = resp_data_i;
        have_d = 1'b1;
      end
      if (retire_i) begin
        req_done_d = 1'b0;
        have_d     = 1'b0;
      end
      if (load_i) begin
        addr_d     = load_addr_i;
        req_done_d = load_is_imm_i;
        have_d     = load_is_imm_i;
        if (load_is_imm_i) data_d = load_imm_i;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_done_q <= 1'b0;
      have_q     <= 1'b0;
      orphan_q   <= 1'b0;
      data_q     <= '0;
      addr_q     <= '0;
    end else begin
      req_done_q <= req_done_d;
      have_q     <= have_d;
      orphan_q   <= orphan_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
    end
  end

endmodule

// File: rtl/eu_operand_sequencer.sv
// Operand sequencer for one execution unit: accepts an instruction, gathers both operands
// from the X buffers or immediates, and hands them to the ALU with a valid/ready handshake.
module eu_operand_sequencer
  import eu_operand_sequencer_pkg::*;
#(
  parameter int DATA_W      = EU_SEQ_DATA_W,
  parameter int ADDR_W      = EU_SEQ_ADDR_W,
  parameter int OPC_W       = EU_SEQ_OPC_W,
  parameter int DEST_W      = EU_SEQ_DEST_W,
  parameter int STALL_CNT_W = EU_SEQ_STALL_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   ireq_valid,
  output logic                   ireq_ready,
  input  logic [OPC_W-1:0]       ireq_opcode,
  input  logic [DEST_W-1:0]      ireq_dest,
  input  logic                   ireq_op0_is_imm,
  input  logic [DATA_W-1:0]      ireq_op0_imm,
  input  logic [ADDR_W-1:0]      ireq_op0_addr,
  input  logic                   ireq_op1_is_imm,
  input  logic [DATA_W-1:0]      ireq_op1_imm,
  input  logic [ADDR_W-1:0]      ireq_op1_addr,
  output logic                   xb0_req_valid,
  output logic [ADDR_W-1:0]      xb0_req_addr,
  input  logic                   xb0_req_ready,
  input  logic                   xb0_resp_valid,
  input  logic [DATA_W-1:0]      xb0_resp_data,
  output logic                   xb1_req_valid,
  output logic [ADDR_W-1:0]      xb1_req_addr,
  input  logic                   xb1_req_ready,
  input  logic                   xb1_resp_valid,
  input  logic [DATA_W-1:0]      xb1_resp_data,
  output logic                   alu_valid,
  input  logic                   alu_ready,
  output logic [DATA_W-1:0]      alu_op0,
  output logic [DATA_W-1:0]      alu_op1,
  output logic [OPC_W-1:0]       alu_opcode,
  output logic [DEST_W-1:0]      alu_dest,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic                   proto_err
);

  type_euseq_state        state_q;
  logic [OPC_W-1:0]       opcode_q;
  logic [DEST_W-1:0]      dest_q;
  logic [STALL_CNT_W-1:0] stall_q;
  logic                   proto_err_q;

  logic            have_next0, have_next1;
  logic            orphan0, orphan1;
  logic            perr0, perr1;
  logic            accept, retire, fetching;
  type_euseq_state accept_state;

  assign fetching     = (state_q == FETCH);
  assign alu_valid    = (state_q == ISSUE) && !flush;
  assign retire       = alu_valid && alu_ready;
  assign ireq_ready   = !flush && !orphan0 && !orphan1 &&
                        ((state_q == IDLE) || ((state_q == ISSUE) && alu_ready));
  assign accept       = ireq_valid && ireq_ready;
  assign accept_state = (ireq_op0_is_imm && ireq_op1_is_imm) ? ISSUE : FETCH;

  assign alu_opcode   = opcode_q;
  assign alu_dest     = dest_q;
  assign stall_cycles = stall_q;
  assign proto_err    = proto_err_q;

  eu_operand_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot0 (
    .clk           (clk),
    .reset         (reset),
    .flush_i       (flush),
    .load_i        (accept),
    .load_is_imm_i (ireq_op0_is_imm),
    .load_imm_i    (ireq_op0_imm),
    .load_addr_i   (ireq_op0_addr),
    .fetch_i       (fetching),
    .retire_i      (retire),
    .req_valid_o   (xb0_req_valid),
    .req_addr_o    (xb0_req_addr),
    .req_ready_i   (xb0_req_ready),
    .resp_valid_i  (xb0_resp_valid),
    .resp_data_i   (xb0_resp_data),
    .data_o        (alu_op0),
    .have_next_o   (have_next0),
    .orphan_o      (orphan0),
    .proto_err_o   (perr0)
  );

  eu_operand_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot1 (
    .clk           (clk),
    .reset         (reset),
    .flush_i       (flush),
    .load_i        (accept),
    .load_is_imm_i (ireq_op1_is_imm),
    .load_imm_i    (ireq_op1_imm),
    .load_addr_i   (ireq_op1_addr),
    .fetch_i       (fetching),
    .retire_i      (retire),
    .req_valid_o   (xb1_req_valid),
    .req_addr_o    (xb1_req_addr),
    .req_ready_i   (xb1_req_ready),
    .resp_valid_i  (xb1_resp_valid),
    .resp_data_i   (xb1_resp_data),
    .data_o        (alu_op1),
    .have_next_o   (have_next1),
    .orphan_o      (orphan1),
    .proto_err_o   (perr1)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      opcode_q    <= '0;
      dest_q      <= '0;
      stall_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (fetching && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (perr0 || perr1) proto_err_q <= 1'b1;
      if (accept) begin
        opcode_q <= ireq_opcode;
        dest_q   <= ireq_dest;
      end

      if (flush) begin
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE:    if (accept) state_q <= accept_state;
          FETCH:   if (have_next0 && have_next1) state_q <= ISSUE;
          ISSUE:   if (retire) state_q <= accept ? accept_state : IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eu_operand_sequencer.sv
// Directed scenarios followed by a randomized run scored against a transaction-level model
// of the sequencer (in-order operand delivery, latency bounds, accumulated fetch cycles).
module tb_eu_operand_sequencer;
  import eu_operand_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        ireq_valid = 1'b0;
  logic        ireq_ready;
  logic [3:0]  ireq_opcode = '0;
  logic [7:0]  ireq_dest = '0;
  logic        ireq_op0_is_imm = 1'b0, ireq_op1_is_imm = 1'b0;
  logic [31:0] ireq_op0_imm = '0, ireq_op1_imm = '0;
  logic [7:0]  ireq_op0_addr = '0, ireq_op1_addr = '0;
  logic        xb0_req_valid, xb1_req_valid;
  logic [7:0]  xb0_req_addr, xb1_req_addr;
  logic        xb0_req_ready = 1'b0, xb1_req_ready = 1'b0;
  logic        xb0_resp_valid = 1'b0, xb1_resp_valid = 1'b0;
  logic [31:0] xb0_resp_data = '0, xb1_resp_data = '0;
  logic        alu_valid;
  logic        alu_ready = 1'b0;
  logic [31:0] alu_op0, alu_op1;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_dest;
  logic [15:0] stall_cycles;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  eu_operand_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .ireq_valid      (ireq_valid),
    .ireq_ready      (ireq_ready),
    .ireq_opcode     (ireq_opcode),
    .ireq_dest       (ireq_dest),
    .ireq_op0_is_imm (ireq_op0_is_imm),
    .ireq_op0_imm    (ireq_op0_imm),
    .ireq_op0_addr   (ireq_op0_addr),
    .ireq_op1_is_imm (ireq_op1_is_imm),
    .ireq_op1_imm    (ireq_op1_imm),
    .ireq_op1_addr   (ireq_op1_addr),
    .xb0_req_valid   (xb0_req_valid),
    .xb0_req_addr    (xb0_req_addr),
    .xb0_req_ready   (xb0_req_ready),
    .xb0_resp_valid  (xb0_resp_valid),
    .xb0_resp_data   (xb0_resp_data),
    .xb1_req_valid   (xb1_req_valid),
    .xb1_req_addr    (xb1_req_addr),
    .xb1_req_ready   (xb1_req_ready),
    .xb1_resp_valid  (xb1_resp_valid),
    .xb1_resp_data   (xb1_resp_data),
    .alu_valid       (alu_valid),
    .alu_ready       (alu_ready),
    .alu_op0         (alu_op0),
    .alu_op1         (alu_op1),
    .alu_opcode      (alu_opcode),
    .alu_dest        (alu_dest),
    .stall_cycles    (stall_cycles),
    .proto_err       (proto_err)
  );

  typedef struct {
    logic [31:0] op0;
    logic [31:0] op1;
    logic [3:0]  opc;
    logic [7:0]  dest;
    int          acc;
    bit          imm2;
  } exp_t;

  typedef struct {
    logic [7:0] addr;
    int         due;
  } rsp_t;

  exp_t eq[$];
  rsp_t rq0[$];
  rsp_t rq1[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  // Contents of X buffer x at address a; differs per buffer so swapped lanes are visible.
  function automatic logic [31:0] xb_data(input int x, input logic [7:0] a);
    return {(x == 0) ? 16'hA0A0 : 16'hB1B1, 8'h5C, a};
  endfunction

  function automatic type_euseq_instr mk(input logic [3:0] opc, input logic [7:0] dst,
                                         input logic i0, input logic [31:0] v0, input logic [7:0] a0,
                                         input logic i1, input logic [31:0] v1, input logic [7:0] a1);
    type_euseq_instr r;
    r.opcode = opc;     r.dest = dst;
    r.op0.is_imm = i0;  r.op0.imm = v0;  r.op0.addr = a0;
    r.op1.is_imm = i1;  r.op1.imm = v1;  r.op1.addr = a1;
    return r;
  endfunction

  task automatic drive(input type_euseq_instr r);
    ireq_valid      = 1'b1;
    ireq_opcode     = r.opcode;
    ireq_dest       = r.dest;
    ireq_op0_is_imm = r.op0.is_imm;
    ireq_op0_imm    = r.op0.imm;
    ireq_op0_addr   = r.op0.addr;
    ireq_op1_is_imm = r.op1.is_imm;
    ireq_op1_imm    = r.op1.imm;
    ireq_op1_addr   = r.op1.addr;
  endtask

  localparam int N_RAND  = 200;
  localparam int MAX_CYC = 20000;

  initial begin
    type_euseq_instr ins;
    exp_t            cur;
    int              cyc, sent, done, lat, stall_sum;
    bit              accepted, head_seen;

    // Reset values while reset is held
    #1;
    check("rst_ireq_ready", 128'(ireq_ready), 128'(1));
    check("rst_req_valid", 128'({xb0_req_valid, xb1_req_valid, alu_valid}), 128'(0));
    check("rst_outputs", 128'({alu_op0, alu_op1, alu_opcode, alu_dest, xb0_req_addr, xb1_req_addr}), 128'(0));
    check("rst_stall_perr", 128'({stall_cycles, proto_err}), 128'(0));
    next();
    reset = 1'b0;

    // Both immediates: alu_valid one cycle after acceptance
    next();
    drive(mk(4'h1, 8'h11, 1'b1, 32'h5, 8'h0, 1'b1, 32'hA, 8'h0));
    alu_ready = 1'b1;
    #1 check("imm_accept_ready", 128'(ireq_ready), 128'(1));
    next();
    ireq_valid = 1'b0;
    #1;
    check("imm_alu_valid", 128'(alu_valid), 128'(1));
    check("imm_alu_data", 128'({alu_op0, alu_op1, alu_opcode, alu_dest}), 128'({32'h5, 32'hA, 4'h1, 8'h11}));
    check("imm_ireq_ready_again", 128'(ireq_ready), 128'(1));
    next();
    #1 check("imm_retired", 128'(alu_valid), 128'(0));

    // Two buffered operands, buffer 1 stalls its request for three cycles
    drive(mk(4'h2, 8'h22, 1'b0, 32'h0, 8'h12, 1'b0, 32'h0, 8'h34));
    xb0_req_ready = 1'b1;
    xb1_req_ready = 1'b0;
    alu_ready     = 1'b0;
    #1 check("fetch_accept_ready", 128'(ireq_ready), 128'(1));
    next();
    ireq_valid = 1'b0;
    #1;
    check("fetch_req_valid", 128'({xb0_req_valid, xb1_req_valid}), 128'(2'b11));
    check("fetch_req_addr", 128'({xb0_req_addr, xb1_req_addr}), 128'({8'h12, 8'h34}));
    next();
    xb0_req_ready  = 1'b0;
    xb0_resp_valid = 1'b1;
    xb0_resp_data  = 32'hAAAA;
    #1 check("fetch_req_after_hs", 128'({xb0_req_valid, xb1_req_valid}), 128'(2'b01));
    next();
    xb0_resp_valid = 1'b0;
    #1;
    check("fetch_op0_held", 128'(alu_op0), 128'(32'hAAAA));
    check("fetch_addr1_stable", 128'({xb1_req_valid, xb1_req_addr}), 128'({1'b1, 8'h34}));
    next();
    xb1_req_ready = 1'b1;
    next();
    xb1_req_ready  = 1'b0;
    xb1_resp_valid = 1'b1;
    xb1_resp_data  = 32'hBBBB;
    #1 check("fetch_not_yet_valid", 128'(alu_valid), 128'(0));

    // ISSUE held for four cycles with the ALU not ready
    for (int i = 0; i < 4; i++) begin
      next();
      xb1_resp_valid = 1'b0;
      #1;
      check("hold_alu_valid", 128'(alu_valid), 128'(1));
      check("hold_alu_data", 128'({alu_op0, alu_op1, alu_opcode, alu_dest}),
            128'({32'hAAAA, 32'hBBBB, 4'h2, 8'h22}));
      check("hold_ireq_ready", 128'(ireq_ready), 128'(0));
      check("hold_stall", 128'(stall_cycles), 128'(5));
    end
    next();
    alu_ready = 1'b1;
    drive(mk(4'h3, 8'h21, 1'b1, 32'h77, 8'h0, 1'b1, 32'h88, 8'h0));
    #1 check("b2b_ireq_ready", 128'(ireq_ready), 128'(1));
    next();
    ireq_valid = 1'b0;
    #1 check("b2b_alu_data", 128'({alu_valid, alu_op0, alu_op1, alu_opcode, alu_dest}),
             128'({1'b1, 32'h77, 32'h88, 4'h3, 8'h21}));
    next();
    #1 check("b2b_retired", 128'(alu_valid), 128'(0));

    // Flush with a request outstanding; the late response must be dropped
    drive(mk(4'h4, 8'h44, 1'b0, 32'h0, 8'h40, 1'b1, 32'h99, 8'h0));
    xb0_req_ready = 1'b1;
    #1 check("flush_accept_ready", 128'(ireq_ready), 128'(1));
    next();
    ireq_valid = 1'b0;
    #1 check("flush_req", 128'({xb0_req_valid, xb0_req_addr, xb1_req_valid}), 128'({1'b1, 8'h40, 1'b0}));
    next();
    xb0_req_ready = 1'b0;
    flush = 1'b1;
    #1 check("flush_cycle", 128'({ireq_ready, alu_valid}), 128'(0));
    next();
    flush = 1'b0;
    xb0_resp_valid = 1'b1;
    xb0_resp_data  = 32'hDEAD;
    #1 check("orphan_blocks", 128'({ireq_ready, alu_valid, xb0_req_valid}), 128'(0));
    next();
    xb0_resp_valid = 1'b0;
    #1;
    check("orphan_cleared", 128'({ireq_ready, alu_valid, proto_err}), 128'(3'b100));
    check("orphan_not_fwd", 128'(alu_op0 != 32'hDEAD), 128'(1));

    // Spurious response while idle
    next();
    xb1_resp_valid = 1'b1;
    xb1_resp_data  = 32'h1234;
    #1 check("perr_before", 128'(proto_err), 128'(0));
    next();
    xb1_resp_valid = 1'b0;
    #1 check("perr_set", 128'(proto_err), 128'(1));
    next();
    next();
    #1 check("perr_sticky", 128'({proto_err, alu_valid}), 128'(2'b10));

    // Asynchronous reset in the middle of FETCH
    next();
    drive(mk(4'h5, 8'h55, 1'b0, 32'h0, 8'h01, 1'b0, 32'h0, 8'h02));
    next();
    ireq_valid = 1'b0;
    #1 check("arst_in_fetch", 128'({xb0_req_valid, xb1_req_valid}), 128'(2'b11));
    #2 reset = 1'b1;
    #1;
    check("arst_flags", 128'({xb0_req_valid, xb1_req_valid, alu_valid, proto_err, ireq_ready}), 128'(1));
    check("arst_data", 128'({alu_op0, alu_op1, alu_opcode, alu_dest, xb0_req_addr, xb1_req_addr}), 128'(0));
    check("arst_stall", 128'(stall_cycles), 128'(0));
    next();
    reset = 1'b0;
    next();
    #1 check("arst_idle", 128'({ireq_ready, xb0_req_valid, xb1_req_valid, alu_valid}), 128'(4'b1000));

    // Randomized traffic against the transaction model
    cyc = 0; sent = 0; done = 0; stall_sum = 0;
    accepted = 1'b0; head_seen = 1'b0;
    ireq_valid = 1'b0;
    cur = '{op0: '0, op1: '0, opc: '0, dest: '0, acc: 0, imm2: 1'b0};
    while (done < N_RAND && cyc < MAX_CYC) begin
      next();
      if (accepted) begin
        ireq_valid = 1'b0;
        accepted   = 1'b0;
      end
      if (!ireq_valid && sent < N_RAND && $urandom_range(0, 9) < 8) begin
        ins = mk(4'($urandom), 8'($urandom),
                 $urandom_range(0, 2) == 0, $urandom, 8'($urandom),
                 $urandom_range(0, 2) == 0, $urandom, 8'($urandom));
        drive(ins);
        cur.op0  = ins.op0.is_imm ? ins.op0.imm : xb_data(0, ins.op0.addr);
        cur.op1  = ins.op1.is_imm ? ins.op1.imm : xb_data(1, ins.op1.addr);
        cur.opc  = ins.opcode;
        cur.dest = ins.dest;
        cur.imm2 = ins.op0.is_imm && ins.op1.is_imm;
        sent++;
      end
      xb0_req_ready = $urandom_range(0, 9) < 6;
      xb1_req_ready = $urandom_range(0, 9) < 6;
      alu_ready     = $urandom_range(0, 9) < 7;
      xb0_resp_valid = (rq0.size() > 0) && (rq0[0].due <= cyc);
      xb1_resp_valid = (rq1.size() > 0) && (rq1[0].due <= cyc);
      xb0_resp_data  = xb0_resp_valid ? xb_data(0, rq0[0].addr) : 32'h0;
      xb1_resp_data  = xb1_resp_valid ? xb_data(1, rq1[0].addr) : 32'h0;
      #1;
      if (xb0_resp_valid) void'(rq0.pop_front());
      if (xb1_resp_valid) void'(rq1.pop_front());
      if (xb0_req_valid && xb0_req_ready)
        rq0.push_back('{addr: xb0_req_addr, due: cyc + 1 + int'($urandom_range(0, 2))});
      if (xb1_req_valid && xb1_req_ready)
        rq1.push_back('{addr: xb1_req_addr, due: cyc + 1 + int'($urandom_range(0, 2))});
      if (alu_valid) begin
        check("rand_ireq_ready", 128'(ireq_ready), 128'(alu_ready));
        if (eq.size() == 0) begin
          check("rand_unexpected_valid", 128'(alu_valid), 128'(0));
        end else begin
          check("rand_alu_data", 128'({alu_op0, alu_op1, alu_opcode, alu_dest}),
                128'({eq[0].op0, eq[0].op1, eq[0].opc, eq[0].dest}));
          if (!head_seen) begin
            head_seen = 1'b1;
            lat = cyc - eq[0].acc;
            stall_sum += lat - 1;
            if (eq[0].imm2) check("rand_imm_latency", 128'(lat), 128'(1));
            else            check("rand_fetch_latency_min", 128'(lat >= 3), 128'(1));
          end
          if (alu_ready) begin
            void'(eq.pop_front());
            head_seen = 1'b0;
            done++;
          end
        end
      end
      if (ireq_valid && ireq_ready) begin
        cur.acc = cyc;
        eq.push_back(cur);
        accepted = 1'b1;
      end
      cyc++;
    end
    check("rand_all_retired", 128'(done), 128'(N_RAND));
    check("rand_stall_total", 128'(stall_cycles), 128'(stall_sum));
    check("rand_no_perr", 128'(proto_err), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
